// File: rtl/wb_dst_tracker_if.sv
// Operand-bypass destination bus between the decode/pipeline side (master)
// and the destination tracker (slave). Carries decoded destination info in
// and the per-stage RegWr/RegDst/MemRead view plus Stall out.
//
// Handshake: there is no valid/ready pair here. The tracker samples the
// decode fields on every rising edge where mem_ready=1 and Stall=0. When
// Stall=1 the master must hold PC and IF/ID and re-present the same decode
// fields on the next cycle. mem_ready=0 freezes the whole tracker.
interface wb_dst_tracker_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             dec_RegWr;
  logic [REG_W-1:0] dec_RegDst;
  logic             dec_MemRead;
  logic [REG_W-1:0] IF_ID_Rs;
  logic [REG_W-1:0] IF_ID_Rt;
  logic             flush;
  logic             mem_ready;

  logic             ID_EX_RegWr;
  logic [REG_W-1:0] ID_EX_RegDst;
  logic             ID_EX_MemRead;
  logic             EX_MEM_RegWr;
  logic [REG_W-1:0] EX_MEM_RegDst;
  logic             MEM_WB_RegWr;
  logic [REG_W-1:0] MEM_WB_RegDst;
  logic             Stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output dec_RegWr, dec_RegDst, dec_MemRead, IF_ID_Rs, IF_ID_Rt,
           flush, mem_ready,
    input  ID_EX_RegWr, ID_EX_RegDst, ID_EX_MemRead, EX_MEM_RegWr,
           EX_MEM_RegDst, MEM_WB_RegWr, MEM_WB_RegDst, Stall, stall_count
  );

  modport slave (
    input  dec_RegWr, dec_RegDst, dec_MemRead, IF_ID_Rs, IF_ID_Rt,
           flush, mem_ready,
    output ID_EX_RegWr, ID_EX_RegDst, ID_EX_MemRead, EX_MEM_RegWr,
           EX_MEM_RegDst, MEM_WB_RegWr, MEM_WB_RegDst, Stall, stall_count
  );
endinterface

// File: rtl/wb_dst_tracker.sv
// Destination tracker for the operand-bypass path. Shadows the ID/EX,
// EX/MEM and MEM/WB pipeline registers with each instruction's
// {RegWr, RegDst, MemRead}, detects load-use hazards and memory wait
// states, and raises Stall while inserting bubbles into ID/EX.
// Optional stall-cycle counter: define WB_DST_TRACKER_STALL_CNT_EN.
module wb_dst_tracker #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  wb_dst_tracker_if.slave  bus
);

  logic             id_ex_regwr_q,   id_ex_regwr_d;
  logic [REG_W-1:0] id_ex_regdst_q,  id_ex_regdst_d;
  logic             id_ex_memread_q, id_ex_memread_d;
  logic             ex_mem_regwr_q,  ex_mem_regwr_d;
  logic [REG_W-1:0] ex_mem_regdst_q, ex_mem_regdst_d;
  logic             mem_wb_regwr_q,  mem_wb_regwr_d;
  logic [REG_W-1:0] mem_wb_regdst_q, mem_wb_regdst_d;
  logic             load_use;
  logic             stall;

  // Hazard detection: a load in ID/EX whose (non-zero) destination is read
  // by the instruction in decode; memory wait states stall everything.
  always_comb begin
    load_use = id_ex_memread_q && (id_ex_regdst_q != '0) &&
               ((id_ex_regdst_q == bus.IF_ID_Rs) ||
                (id_ex_regdst_q == bus.IF_ID_Rt));
    stall    = load_use || !bus.mem_ready;
  end

  // Next-state: hold on wait state, otherwise shift and load ID/EX with
  // either the decoded instruction or a bubble (flush wins over load-use).
  always_comb begin
    id_ex_regwr_d   = id_ex_regwr_q;
    id_ex_regdst_d  = id_ex_regdst_q;
    id_ex_memread_d = id_ex_memread_q;
    ex_mem_regwr_d  = ex_mem_regwr_q;
    ex_mem_regdst_d = ex_mem_regdst_q;
    mem_wb_regwr_d  = mem_wb_regwr_q;
    mem_wb_regdst_d = mem_wb_regdst_q;
    if (bus.mem_ready) begin
      mem_wb_regwr_d  = ex_mem_regwr_q;
      mem_wb_regdst_d = ex_mem_regdst_q;
      ex_mem_regwr_d  = id_ex_regwr_q;
      ex_mem_regdst_d = id_ex_regdst_q;
      if (bus.flush || load_use) begin
        id_ex_regwr_d   = 1'b0;
        id_ex_regdst_d  = '0;
        id_ex_memread_d = 1'b0;
      end else begin
        id_ex_regwr_d   = bus.dec_RegWr;
        id_ex_regdst_d  = bus.dec_RegDst;
        id_ex_memread_d = bus.dec_MemRead;
      end
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      id_ex_regwr_q   <= 1'b0;
      id_ex_regdst_q  <= '0;
      id_ex_memread_q <= 1'b0;
      ex_mem_regwr_q  <= 1'b0;
      ex_mem_regdst_q <= '0;
      mem_wb_regwr_q  <= 1'b0;
      mem_wb_regdst_q <= '0;
    end else begin
      id_ex_regwr_q   <= id_ex_regwr_d;
      id_ex_regdst_q  <= id_ex_regdst_d;
      id_ex_memread_q <= id_ex_memread_d;
      ex_mem_regwr_q  <= ex_mem_regwr_d;
      ex_mem_regdst_q <= ex_mem_regdst_d;
      mem_wb_regwr_q  <= mem_wb_regwr_d;
      mem_wb_regdst_q <= mem_wb_regdst_d;
    end
  end

`ifdef WB_DST_TRACKER_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = '0;
`endif

  assign bus.ID_EX_RegWr   = id_ex_regwr_q;
  assign bus.ID_EX_RegDst  = id_ex_regdst_q;
  assign bus.ID_EX_MemRead = id_ex_memread_q;
  assign bus.EX_MEM_RegWr  = ex_mem_regwr_q;
  assign bus.EX_MEM_RegDst = ex_mem_regdst_q;
  assign bus.MEM_WB_RegWr  = mem_wb_regwr_q;
  assign bus.MEM_WB_RegDst = mem_wb_regdst_q;
  assign bus.Stall         = stall;

endmodule

// File: tb/tb_wb_dst_tracker.sv
// Bench for wb_dst_tracker: directed scenarios followed by random traffic.
// A behavioural pipeline model produces the expected post-edge state, which
// is queued when stimulus is driven and compared after the edge.
module tb_wb_dst_tracker;
  localparam int REG_W = 5;
  localparam int CNT_W = 2;
  localparam int EW    = 3*REG_W + 4 + CNT_W;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [EW-1:0] exp_q[$];

  wb_dst_tracker_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  wb_dst_tracker #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic             m_id_wr, m_id_mr, m_ex_wr, m_wb_wr;
  logic [REG_W-1:0] m_id_dst, m_ex_dst, m_wb_dst;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check Stall, advance the model, check outputs.
  task automatic step(input logic rst_n, input logic wr,
                      input logic [REG_W-1:0] dst, input logic mr,
                      input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                      input logic fl, input logic rdy);
    logic             lu, st;
    logic             e_id_wr, e_id_mr, e_ex_wr, e_wb_wr;
    logic [REG_W-1:0] e_id_dst, e_ex_dst, e_wb_dst;
    logic [CNT_W-1:0] e_cnt;
    reset           = rst_n;
    bus.dec_RegWr   = wr;
    bus.dec_RegDst  = dst;
    bus.dec_MemRead = mr;
    bus.IF_ID_Rs    = rs;
    bus.IF_ID_Rt    = rt;
    bus.flush       = fl;
    bus.mem_ready   = rdy;
    #1;
    lu = m_id_mr && (m_id_dst != 0) && (m_id_dst == rs || m_id_dst == rt);
    st = lu || !rdy;
    check("stall", {31'd0, bus.Stall}, {31'd0, st});
    if (!rst_n) begin
      m_id_wr = 0; m_id_dst = 0; m_id_mr = 0;
      m_ex_wr = 0; m_ex_dst = 0; m_wb_wr = 0; m_wb_dst = 0;
      m_cnt = 0;
    end else begin
`ifdef WB_DST_TRACKER_STALL_CNT_EN
      if (st && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
`endif
      if (rdy) begin
        m_wb_wr = m_ex_wr; m_wb_dst = m_ex_dst;
        m_ex_wr = m_id_wr; m_ex_dst = m_id_dst;
        if (fl || lu) begin
          m_id_wr = 0; m_id_dst = 0; m_id_mr = 0;
        end else begin
          m_id_wr = wr; m_id_dst = dst; m_id_mr = mr;
        end
      end
    end
    exp_q.push_back({m_id_wr, m_id_dst, m_id_mr, m_ex_wr, m_ex_dst,
                     m_wb_wr, m_wb_dst, m_cnt});
    @(posedge clk);
    #1;
    {e_id_wr, e_id_dst, e_id_mr, e_ex_wr, e_ex_dst, e_wb_wr, e_wb_dst, e_cnt}
      = exp_q.pop_front();
    check("id_ex_regwr",   {31'd0, bus.ID_EX_RegWr},   {31'd0, e_id_wr});
    check("id_ex_regdst",  {27'd0, bus.ID_EX_RegDst},  {27'd0, e_id_dst});
    check("id_ex_memread", {31'd0, bus.ID_EX_MemRead}, {31'd0, e_id_mr});
    check("ex_mem_regwr",  {31'd0, bus.EX_MEM_RegWr},  {31'd0, e_ex_wr});
    check("ex_mem_regdst", {27'd0, bus.EX_MEM_RegDst}, {27'd0, e_ex_dst});
    check("mem_wb_regwr",  {31'd0, bus.MEM_WB_RegWr},  {31'd0, e_wb_wr});
    check("mem_wb_regdst", {27'd0, bus.MEM_WB_RegDst}, {27'd0, e_wb_dst});
    check("stall_count",   {30'd0, bus.stall_count},   {30'd0, e_cnt});
    @(negedge clk);
  endtask

  // driver task: plain advancing instruction, no hazard sources
  task automatic instr(input logic wr, input logic [REG_W-1:0] dst,
                       input logic mr, input logic [REG_W-1:0] rs,
                       input logic [REG_W-1:0] rt);
    step(1'b1, wr, dst, mr, rs, rt, 1'b0, 1'b1);
  endtask

  task automatic bubble();
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_id_wr = 0; m_id_dst = 0; m_id_mr = 0;
    m_ex_wr = 0; m_ex_dst = 0; m_wb_wr = 0; m_wb_dst = 0; m_cnt = 0;
    reset = 1'b0;
    bus.dec_RegWr = 0; bus.dec_RegDst = 0; bus.dec_MemRead = 0;
    bus.IF_ID_Rs = 0; bus.IF_ID_Rt = 0; bus.flush = 0; bus.mem_ready = 1;
    @(negedge clk);

    // reset
    step(1'b0, 1'b1, 5'd7, 1'b1, 5'd1, 5'd2, 1'b0, 1'b1);
    step(1'b0, 1'b1, 5'd7, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0);

    // single write to r8 walks through all three stages
    instr(1'b1, 5'd8, 1'b0, 5'd1, 5'd2);
    bubble(); bubble(); bubble();

    // load r9, dependent on Rs=9: one bubble, then decode re-presented
    instr(1'b1, 5'd9, 1'b1, 5'd0, 5'd0);
    instr(1'b1, 5'd10, 1'b0, 5'd9, 5'd3);
    instr(1'b1, 5'd10, 1'b0, 5'd9, 5'd3);
    bubble(); bubble();

    // dependency through Rt
    instr(1'b1, 5'd12, 1'b1, 5'd0, 5'd0);
    instr(1'b0, 5'd0, 1'b0, 5'd1, 5'd12);
    instr(1'b0, 5'd0, 1'b0, 5'd1, 5'd12);

    // load r0 then use r0; load r9 then use r10: no hazard
    instr(1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    instr(1'b1, 5'd5, 1'b0, 5'd0, 5'd0);
    instr(1'b1, 5'd9, 1'b1, 5'd0, 5'd0);
    instr(1'b1, 5'd6, 1'b0, 5'd10, 5'd10);

    // back-to-back loads to the same register, each obeys load-use
    instr(1'b1, 5'd11, 1'b1, 5'd0, 5'd0);
    instr(1'b1, 5'd11, 1'b1, 5'd11, 5'd0);
    instr(1'b1, 5'd11, 1'b1, 5'd11, 5'd0);
    instr(1'b1, 5'd2, 1'b0, 5'd11, 5'd0);
    instr(1'b1, 5'd2, 1'b0, 5'd11, 5'd0);

    // flush and load-use together
    instr(1'b1, 5'd9, 1'b1, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd13, 1'b0, 5'd9, 5'd0, 1'b1, 1'b1);
    instr(1'b1, 5'd13, 1'b0, 5'd9, 5'd0);

    // write r3 then r4 then r5, then three wait states, then resume
    instr(1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
    instr(1'b1, 5'd4, 1'b0, 5'd0, 5'd0);
    instr(1'b1, 5'd5, 1'b1, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 5'd20, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0);
    instr(1'b1, 5'd20, 1'b0, 5'd1, 5'd1);
    bubble();

    // five stall cycles then reset mid-stall, then normal advance
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    instr(1'b1, 5'd21, 1'b0, 5'd0, 5'd0);

    // random traffic over a small register range to hit hazards often
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 4) != 0));
    end

    // final report
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_dst_tracker.md
Name: wb_dst_tracker

Overview:
- Producer side of the operand-bypass interface: carries each instruction's destination info (RegWr, RegDst, MemRead) from decode through ID/EX, EX/MEM and MEM/WB.
- Presents EX_MEM_* and MEM_WB_* to the forwarding logic.
- Detects load-use hazards and memory wait states, and issues Stall plus bubble insertion.
- Sits beside the pipeline registers in the core; one instance per core.

Parameters:
REG_W, 5, register-index width
CNT_W, 16, stall-counter width (optional feature only)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset
dec_RegWr  in  1  decoded instruction writes a register
dec_RegDst  in  REG_W  decoded destination register
dec_MemRead  in  1  decoded instruction is a load
IF_ID_Rs  in  REG_W  source Rs of instruction in decode
IF_ID_Rt  in  REG_W  source Rt of instruction in decode
flush  in  1  squash instruction entering ID/EX (taken branch/jump)
mem_ready  in  1  data memory completes this cycle; 0 = wait state
ID_EX_RegWr  out  1  ID/EX stage write enable
ID_EX_RegDst  out  REG_W  ID/EX destination
ID_EX_MemRead  out  1  ID/EX stage is a load
EX_MEM_RegWr  out  1  to forwarding logic
EX_MEM_RegDst  out  REG_W  to forwarding logic
MEM_WB_RegWr  out  1  to forwarding logic / register file
MEM_WB_RegDst  out  REG_W  to forwarding logic / register file
Stall  out  1  hold PC and IF/ID this cycle
stall_count  out  CNT_W  stall cycle count (optional feature)

Behaviour:
- Reset: when reset=0 at a rising clk edge, all stage registers clear.
  - All RegWr, MemRead and RegDst outputs = 0; stall_count = 0.
  - Reset overrides every other input.
  - Reset asserted mid-stall clears the stall; the first cycle after reset releases behaves as normal advance.
- A "bubble" is {RegWr=0, RegDst=0, MemRead=0}.
- load_use (combinational):
  - Condition: ID_EX_MemRead=1 and ID_EX_RegDst!=0 and (ID_EX_RegDst==IF_ID_Rs or ID_EX_RegDst==IF_ID_Rt).
  - Destination 0 never causes a hazard.
- Stall (combinational) = load_use OR (mem_ready==0).
- Per clock edge, priority order, reset high:
  1. Freeze: mem_ready=0. All three stages hold their values; flush and load_use are ignored this edge, but flush is the caller's to re-assert.
  2. Advance: otherwise MEM_WB <= EX_MEM; EX_MEM <= ID_EX (MemRead is dropped past ID/EX).
  3. ID/EX load:
     - flush=1: bubble (flush beats load_use).
     - else load_use=1: bubble. Decode is held by Stall and re-presented next cycle.
     - else: {dec_RegWr, dec_RegDst, dec_MemRead}.
- Latency:
  - A decoded instruction appears on ID_EX_* 1 cycle after acceptance, EX_MEM_* after 2, MEM_WB_* after 3, absent stalls.
  - Each load-use adds exactly one bubble.
- Back-to-back loads to the same register: each load independently obeys the load-use rule; no merged stalls.
- dec_RegWr=1 with dec_RegDst=0 is carried as-is. Suppressing register 0 is the consumer's job.
- All outputs are registered except Stall.

Optional Feature:
- Macro: WB_DST_TRACKER_STALL_CNT_EN.
- Defined:
  - stall_count increments by 1 on each rising edge where reset=1 and Stall=1.
  - Saturates at 2^CNT_W-1; cleared only by reset.
- Undefined: stall_count is driven constant 0 and no counter flops are generated.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then dec_RegWr=1, dec_RegDst=5'd8, MemRead=0 for one cycle, then bubbles -> ID_EX_RegDst=8 at cycle 1, EX_MEM_RegDst=8 at cycle 2, MEM_WB_RegDst=8 at cycle 3, Stall=0 throughout.
- Load to r9 (MemRead=1), next decode has IF_ID_Rs=9 -> Stall=1 for exactly one cycle; ID_EX becomes bubble; the dependent instruction enters ID_EX next cycle; EX_MEM_RegDst=9 one cycle after the load left ID/EX.
- Load to r0 followed by use of r0; and load to r9 followed by use of r10 -> Stall stays 0 in both cases.
- flush=1 and load_use both true on the same edge -> ID_EX is a bubble, and Stall=1 that cycle only.
- mem_ready=0 for 3 cycles with EX_MEM_RegDst=4 and MEM_WB_RegDst=3 -> all outputs frozen, Stall=1 for 3 cycles; pipeline resumes advancing on the first edge with mem_ready=1.
- With WB_DST_TRACKER_STALL_CNT_EN and CNT_W=2: 5 stall cycles -> stall_count reads 1, 2, 3, 3, 3; reset=0 -> 0. Without the macro -> stall_count is always 0.
